// File: rtl/core_uarch_pkg.sv
// Shared micro-architecture types for the core: register numbers, data words
// and the writeback line carried from execution units to the register file.
package core_uarch;

  localparam int WB_REG_BITS = 4;
  localparam int WB_W        = 32;

  typedef logic [WB_REG_BITS-1:0] reg_num;
  typedef logic [WB_W-1:0]        word;

  typedef struct packed {
    logic   valid;
    reg_num rd;
    word    value;
  } wb_line;

  // Folds idx back into 0..n-1; callers never pass anything at or above 2*n.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/core_writeback_arb_pick.sv
// Round-robin picker: scans candidates from the rotate pointer and grants the
// first N_PORTS whose destination register is not already claimed this cycle.
module core_wb_rr_pick
  import core_uarch::*;
#(
  parameter int N_SRC    = 5,
  parameter int N_PORTS  = 2,
  parameter int REG_BITS = 4,
  parameter int ZERO_REG = 0,
  localparam int IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int MASK    = 1 << REG_BITS
) (
  input  logic [N_SRC-1:0]          cand_valid_i,
  input  logic [N_SRC*REG_BITS-1:0] cand_rd_i,
  input  logic [IW-1:0]             rr_i,
  output logic [N_SRC-1:0]          grant_o,
  output logic [N_SRC-1:0]          use_port_o,
  output logic [N_SRC*PW-1:0]       port_idx_o,
  output logic                      any_grant_o,
  output logic [IW-1:0]             last_o
);

  logic [REG_BITS-1:0] candRd [N_SRC];
  logic [PW-1:0]       portIdx [N_SRC];
  logic [MASK-1:0]     taken;
  logic [IW-1:0]       idx;
  logic [REG_BITS-1:0] rd;
  int                  cnt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign candRd[g]                  = cand_rd_i[g*REG_BITS +: REG_BITS];
    assign port_idx_o[g*PW +: PW]     = portIdx[g];
  end

  // Register-zero lines (when dropped) take no port and claim no register.
  always_comb begin
    grant_o     = '0;
    use_port_o  = '0;
    any_grant_o = 1'b0;
    last_o      = '0;
    taken       = '0;
    cnt         = 0;
    idx         = '0;
    rd          = '0;
    for (int i = 0; i < N_SRC; i++) portIdx[i] = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = IW'(wrap_idx(int'(rr_i) + k, N_SRC));
      rd  = candRd[idx];
      if (cand_valid_i[idx]) begin
        if (ZERO_REG != 0 && rd == '0) begin
          grant_o[idx] = 1'b1;
          any_grant_o  = 1'b1;
          last_o       = idx;
        end else if (cnt < N_PORTS && !taken[rd]) begin
          grant_o[idx]    = 1'b1;
          use_port_o[idx] = 1'b1;
          portIdx[idx]    = PW'(cnt);
          taken[rd]       = 1'b1;
          cnt             = cnt + 1;
          any_grant_o     = 1'b1;
          last_o          = idx;
        end
      end
    end
  end

endmodule

// File: rtl/core_writeback_arb.sv
// N-source to M-port writeback arbiter: per-source skid entries, round-robin
// fairness, same-register ordering and a pending-write mask for dispatch.
module core_writeback_arb
  import core_uarch::*;
#(
  parameter int N_SRC    = 5,
  parameter int N_PORTS  = 2,
  parameter int REG_BITS = core_uarch::WB_REG_BITS,
  parameter int W        = core_uarch::WB_W,
  parameter int ZERO_REG = 0,
  localparam int IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int MASK    = 1 << REG_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            src_valid_i,
  input  logic [N_SRC*REG_BITS-1:0]   src_rd_i,
  input  logic [N_SRC*W-1:0]          src_value_i,
  output logic [N_SRC-1:0]            wb_stall_o,
  output logic [N_PORTS-1:0]          wr_valid_o,
  output logic [N_PORTS*REG_BITS-1:0] wr_rd_o,
  output logic [N_PORTS*W-1:0]        wr_value_o,
  output logic [MASK-1:0]             pending_mask_o
);

  logic [REG_BITS-1:0]       srcRd [N_SRC];
  logic [W-1:0]              srcValue [N_SRC];
  logic [N_SRC-1:0]          candValid;
  logic [REG_BITS-1:0]       candRd [N_SRC];
  logic [W-1:0]              candValue [N_SRC];
  logic [N_SRC*REG_BITS-1:0] candRdFlat;

  logic [N_SRC-1:0]    skidValid_q, skidValid_d;
  logic [REG_BITS-1:0] skidRd_q [N_SRC];
  logic [REG_BITS-1:0] skidRd_d [N_SRC];
  logic [W-1:0]        skidValue_q [N_SRC];
  logic [W-1:0]        skidValue_d [N_SRC];

  logic [N_PORTS-1:0]  wrValid_q, wrValid_d;
  logic [REG_BITS-1:0] wrRd_q [N_PORTS];
  logic [REG_BITS-1:0] wrRd_d [N_PORTS];
  logic [W-1:0]        wrValue_q [N_PORTS];
  logic [W-1:0]        wrValue_d [N_PORTS];

  logic [IW-1:0] rr_q, rr_d;

  logic [N_SRC-1:0]    grant;
  logic [N_SRC-1:0]    usePort;
  logic [N_SRC*PW-1:0] portIdxFlat;
  logic [PW-1:0]       portIdx [N_SRC];
  logic                anyGrant;
  logic [IW-1:0]       lastGrant;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign srcRd[g]                            = src_rd_i[g*REG_BITS +: REG_BITS];
    assign srcValue[g]                         = src_value_i[g*W +: W];
    assign candRdFlat[g*REG_BITS +: REG_BITS]  = candRd[g];
    assign portIdx[g]                          = portIdxFlat[g*PW +: PW];
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign wr_rd_o[p*REG_BITS +: REG_BITS] = wrRd_q[p];
    assign wr_value_o[p*W +: W]            = wrValue_q[p];
  end

  assign wr_valid_o = wrValid_q;
  assign wb_stall_o = skidValid_q;

  // A held line always outranks whatever the source is presenting.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      candValid[i] = skidValid_q[i] | src_valid_i[i];
      candRd[i]    = skidValid_q[i] ? skidRd_q[i]    : srcRd[i];
      candValue[i] = skidValid_q[i] ? skidValue_q[i] : srcValue[i];
    end
  end

  core_wb_rr_pick #(
    .N_SRC    (N_SRC),
    .N_PORTS  (N_PORTS),
    .REG_BITS (REG_BITS),
    .ZERO_REG (ZERO_REG)
  ) u_pick (
    .cand_valid_i (candValid),
    .cand_rd_i    (candRdFlat),
    .rr_i         (rr_q),
    .grant_o      (grant),
    .use_port_o   (usePort),
    .port_idx_o   (portIdxFlat),
    .any_grant_o  (anyGrant),
    .last_o       (lastGrant)
  );

  // Fresh lines that lose arbitration park in the skid; a fresh line arriving
  // while the skid is already occupied is dropped.
  always_comb begin
    skidValid_d = skidValid_q;
    skidRd_d    = skidRd_q;
    skidValue_d = skidValue_q;
    wrValid_d   = '0;
    wrRd_d      = wrRd_q;
    wrValue_d   = wrValue_q;
    rr_d        = rr_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (skidValid_q[i]) begin
        if (grant[i]) skidValid_d[i] = 1'b0;
      end else if (src_valid_i[i] && !grant[i]) begin
        skidValid_d[i] = 1'b1;
        skidRd_d[i]    = srcRd[i];
        skidValue_d[i] = srcValue[i];
      end
      if (usePort[i]) begin
        wrValid_d[portIdx[i]] = 1'b1;
        wrRd_d[portIdx[i]]    = candRd[i];
        wrValue_d[portIdx[i]] = candValue[i];
      end
    end
    if (anyGrant) rr_d = IW'(wrap_idx(int'(lastGrant) + 1, N_SRC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skidValid_q <= '0;
      wrValid_q   <= '0;
      rr_q        <= '0;
    end else begin
      skidValid_q <= skidValid_d;
      wrValid_q   <= wrValid_d;
      rr_q        <= rr_d;
    end
    skidRd_q    <= skidRd_d;
    skidValue_q <= skidValue_d;
    wrRd_q      <= wrRd_d;
    wrValue_q   <= wrValue_d;
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < N_SRC; i++)
      if (skidValid_q[i]) pending_mask_o[skidRd_q[i]] = 1'b1;
    for (int p = 0; p < N_PORTS; p++)
      if (wrValid_q[p]) pending_mask_o[wrRd_q[p]] = 1'b1;
  end

endmodule
